dp_mem_model: RTL
=================

Name: dp_mem_model

Overview:
- Parametrised single-clock, dual-port behavioural memory for simulation.
- Port A is a read-only instruction port. Port B is a read/write data port with per-byte write strobes.
- Read data emerges after a configurable pipeline latency, with a valid flag and a global hold input for core stalls.
- Replaces the fixed 2-cycle, word-write model in the core's Verilator bench.

Parameters:
DATA_WID, 32, word width in bits; must be a multiple of 8
ADDR_WID, 14, word-address width
DEPTH, 16384, number of words; must satisfy DEPTH <= 2**ADDR_WID
READ_LAT, 2, cycles from accepted request to rvalid; legal range 1..4
WR_FWD, 0, A-read/B-write same-address collision: 0 returns the old word, 1 returns the merged new word

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
hold  in  1  freezes both read pipelines and blocks new requests
a_req  in  1  port A read request
a_addr  in  ADDR_WID  port A word address
a_rdata  out  DATA_WID  port A read data
a_rvalid  out  1  port A read data valid
b_req  in  1  port B request (read, or write if any strobe set)
b_we  in  DATA_WID/8  port B byte write strobes
b_addr  in  ADDR_WID  port B word address
b_wdata  in  DATA_WID  port B write data
b_rdata  out  DATA_WID  port B read data
b_rvalid  out  1  port B data valid

Behaviour:
- Reset (asynchronous, active-low) clears immediately:
  - a_rdata = 0, b_rdata = 0, a_rvalid = 0, b_rvalid = 0
  - all pipeline stages and stage valids
  - The memory array is NOT cleared; contents survive reset.
- Request acceptance: a request is accepted on a rising edge where req = 1 and hold = 0.
- Pipeline: each port has a READ_LAT-deep data/valid shift register.
  - Stage 0 is loaded at acceptance. Stage READ_LAT-1 drives rdata/rvalid.
  - An accepted request at edge N gives rvalid = 1 in the cycle after edge N+READ_LAT-1.
  - READ_LAT = 2 gives the same timing as the previous model.
- Idle: with req = 0 and hold = 0, a bubble (valid = 0) enters stage 0. Data in a bubble stage holds its previous value.
- Hold: while hold = 1, no pipeline stage, rdata or rvalid changes, and no write is performed. On release, the pipeline resumes exactly where it stopped.
- Port B write: an accepted request with b_we != 0 updates only the bytes whose strobe is set: mem[b_addr] = (old & ~mask) | (b_wdata & mask).
  - The response is write-first: the merged word enters the B pipeline with valid = 1.
  - b_we = 0 is a plain read.
- A/B same-address collision (same edge, a_addr == b_addr, B writing):
  - WR_FWD = 0: A returns the pre-write word.
  - WR_FWD = 1: A returns the merged word.
  - Two reads to the same address have no hazard.
- Back-to-back: one request per port per cycle. A write at edge N followed by a read at edge N+1 returns the new data.
- Address width: addresses are used unsigned with no wrap.
  - DEPTH == 2**ADDR_WID: every address is valid.
  - Otherwise, addresses >= DEPTH are handled by the optional feature (see below).
- Simultaneous hold and reset: reset wins.
- Reset mid-operation: in-flight reads are discarded. A write accepted before reset remains in the array.
- Elaboration: an illegal READ_LAT, a DEPTH > 2**ADDR_WID, or a DATA_WID that is not a multiple of 8 fails elaboration via $error.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN
- When defined, two extra outputs are added: a_err and b_err, each 1 bit, reset value 0.
  - An accepted request with addr >= DEPTH travels the pipeline as an error token.
  - At output, err = 1 and rvalid = 1 in the same cycle, with rdata = 0.
  - An out-of-range write is dropped and the array is unchanged.
  - $display reports the port and address.
- When undefined:
  - The err ports do not exist.
  - An out-of-range read returns X.
  - An out-of-range write is ignored.

Test Plan:
- Latency sweep, READ_LAT = 1..4: preload mem[5] = 0xDEADBEEF, assert a_req with a_addr = 5 for one cycle -> a_rvalid pulses exactly READ_LAT cycles later with 0xDEADBEEF, and no other valid pulse occurs.
- Byte strobes: mem[9] = 0x11223344; B write b_we = 4'b0101, b_wdata = 0xAABBCCDD -> b_rdata = 0x11BB33DD with b_rvalid; a later A read of address 9 returns 0x11BB33DD.
- Collision: mem[3] = 0x0; same edge A reads 3 and B writes 0xFFFFFFFF to 3 with all strobes -> A returns 0x0 when WR_FWD = 0 and 0xFFFFFFFF when WR_FWD = 1.
- Hold: issue A reads to 0, 1, 2 on consecutive cycles and assert hold for 3 cycles mid-stream -> outputs are frozen during hold, all three results are delivered in order after release, and a req presented during hold is not accepted.
- Reset mid-flight: B write 0x1234 to 7, then an A read of 7, then pull rst_n low asynchronously between edges -> rvalid = 0 and rdata = 0 immediately; after reset, a fresh A read of 7 returns 0x1234.
- MEM_BOUNDS_CHECK_EN with DEPTH = 1000, ADDR_WID = 10: A read of address 1000 -> a_err = 1, a_rvalid = 1, a_rdata = 0; B write to 1023 -> b_err = 1 and the array is unchanged.

Source files
------------

// File: rtl/dp_mem_model.sv
// dp_mem_model: single-clock dual-port behavioural memory; port A reads, port B reads or byte-strobe writes.
// Latency: READ_LAT cycles (1..4) from accepted request to rvalid; one request per port per cycle.
// Backpressure: hold freezes both pipelines, rdata/rvalid and writes, and refuses requests. MEM_BOUNDS_CHECK_EN adds a_err/b_err.
module dp_mem_model #(
  parameter int DATA_WID = 32,
  parameter int ADDR_WID = 14,
  parameter int DEPTH    = 16384,
  parameter int READ_LAT = 2,
  parameter int WR_FWD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  hold,
  input  logic                  a_req,
  input  logic [ADDR_WID-1:0]   a_addr,
  output logic [DATA_WID-1:0]   a_rdata,
  output logic                  a_rvalid,
  input  logic                  b_req,
  input  logic [DATA_WID/8-1:0] b_we,
  input  logic [ADDR_WID-1:0]   b_addr,
  input  logic [DATA_WID-1:0]   b_wdata,
  output logic [DATA_WID-1:0]   b_rdata,
  output logic                  b_rvalid
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic                  a_err,
  output logic                  b_err
`endif
);

  localparam int NB    = DATA_WID / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH widened by one bit so DEPTH == 2**ADDR_WID is representable.
  localparam logic [ADDR_WID:0] DEPTH_EXT = (ADDR_WID + 1)'(DEPTH);

  // Reject configurations the pipeline and byte merge cannot represent.
  generate
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
      $error("dp_mem_model: READ_LAT=%0d outside 1..4", READ_LAT);
    end
    if (longint'(DEPTH) > (longint'(1) << ADDR_WID)) begin : g_bad_depth
      $error("dp_mem_model: DEPTH=%0d exceeds 2**ADDR_WID", DEPTH);
    end
    if ((DATA_WID % 8) != 0 || DATA_WID < 8) begin : g_bad_wid
      $error("dp_mem_model: DATA_WID=%0d not a multiple of 8", DATA_WID);
    end
  endgenerate

  // Storage is deliberately never reset: contents survive rst_n.
  logic [DATA_WID-1:0] mem [DEPTH];

  logic                a_acc, b_acc, b_wr;
  logic                a_in_rng, b_in_rng;
  logic [IDX_W-1:0]    a_idx, b_idx;
  logic [DATA_WID-1:0] b_mask, a_old, b_old, b_merged;
  logic [DATA_WID-1:0] a_rd, b_rd;

  logic [DATA_WID-1:0] a_dat_q [READ_LAT];
  logic [DATA_WID-1:0] a_dat_d [READ_LAT];
  logic [READ_LAT-1:0] a_vld_q, a_vld_d;
  logic [DATA_WID-1:0] b_dat_q [READ_LAT];
  logic [DATA_WID-1:0] b_dat_d [READ_LAT];
  logic [READ_LAT-1:0] b_vld_q, b_vld_d;
`ifdef MEM_BOUNDS_CHECK_EN
  logic [READ_LAT-1:0] a_err_q, a_err_d;
  logic [READ_LAT-1:0] b_err_q, b_err_d;
`endif

  // Request decode, array lookup, byte merge and collision resolution.
  always_comb begin
    a_acc    = a_req & ~hold;
    b_acc    = b_req & ~hold;
    b_wr     = b_acc & (|b_we);
    a_in_rng = ({1'b0, a_addr} < DEPTH_EXT);
    b_in_rng = ({1'b0, b_addr} < DEPTH_EXT);
    a_idx    = a_addr[IDX_W-1:0];
    b_idx    = b_addr[IDX_W-1:0];
    b_mask   = '0;
    for (int i = 0; i < NB; i++) begin
      b_mask[8*i +: 8] = {8{b_we[i]}};
    end
    a_old    = mem[a_idx];
    b_old    = mem[b_idx];
    b_merged = (b_old & ~b_mask) | (b_wdata & b_mask);

    // Out-of-range: an error token carries zero data, otherwise the word is undefined.
    if (!a_in_rng) begin
`ifdef MEM_BOUNDS_CHECK_EN
      a_rd = '0;
`else
      a_rd = 'x;
`endif
    end else if ((WR_FWD != 0) && b_wr && b_in_rng && (a_addr == b_addr)) begin
      a_rd = b_merged;
    end else begin
      a_rd = a_old;
    end

    // B responses are write-first: a write returns the merged word.
    if (!b_in_rng) begin
`ifdef MEM_BOUNDS_CHECK_EN
      b_rd = '0;
`else
      b_rd = 'x;
`endif
    end else if (|b_we) begin
      b_rd = b_merged;
    end else begin
      b_rd = b_old;
    end
  end

  // Port A pipeline advance; bubble stages keep their previous data.
  always_comb begin
    a_vld_d = a_vld_q;
    a_dat_d = a_dat_q;
    if (!hold) begin
      a_vld_d[0] = a_acc;
      if (a_acc) begin
        a_dat_d[0] = a_rd;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        a_vld_d[i] = a_vld_q[i-1];
        if (a_vld_q[i-1]) begin
          a_dat_d[i] = a_dat_q[i-1];
        end
      end
    end
  end

  // Port B pipeline advance; bubble stages keep their previous data.
  always_comb begin
    b_vld_d = b_vld_q;
    b_dat_d = b_dat_q;
    if (!hold) begin
      b_vld_d[0] = b_acc;
      if (b_acc) begin
        b_dat_d[0] = b_rd;
      end
      for (int i = 1; i < READ_LAT; i++) begin
        b_vld_d[i] = b_vld_q[i-1];
        if (b_vld_q[i-1]) begin
          b_dat_d[i] = b_dat_q[i-1];
        end
      end
    end
  end

`ifdef MEM_BOUNDS_CHECK_EN
  // Error tokens ride alongside the valid bits; a bubble never carries an error.
  always_comb begin
    a_err_d = a_err_q;
    b_err_d = b_err_q;
    if (!hold) begin
      a_err_d[0] = a_acc & ~a_in_rng;
      b_err_d[0] = b_acc & ~b_in_rng;
      for (int i = 1; i < READ_LAT; i++) begin
        a_err_d[i] = a_err_q[i-1];
        b_err_d[i] = b_err_q[i-1];
      end
    end
  end

  // Error flag registers; in-flight errors are discarded by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_err_q <= '0;
      b_err_q <= '0;
    end else begin
      a_err_q <= a_err_d;
      b_err_q <= b_err_d;
    end
  end

  assign a_err = a_err_q[READ_LAT-1];
  assign b_err = b_err_q[READ_LAT-1];
`endif

  // Pipeline registers; reset discards all in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_vld_q <= '0;
      a_dat_q <= '{default: '0};
      b_vld_q <= '0;
      b_dat_q <= '{default: '0};
    end else begin
      a_vld_q <= a_vld_d;
      a_dat_q <= a_dat_d;
      b_vld_q <= b_vld_d;
      b_dat_q <= b_dat_d;
    end
  end

  // Array write of accepted in-range B writes; out-of-range writes are dropped.
  always_ff @(posedge clk) begin
    if (b_wr && b_in_rng) begin
      mem[b_idx] <= b_merged;
    end
`ifdef MEM_BOUNDS_CHECK_EN
    if (rst_n && a_acc && !a_in_rng) begin
      $display("dp_mem_model: port A address 0x%0h out of range", a_addr);
    end
    if (rst_n && b_acc && !b_in_rng) begin
      $display("dp_mem_model: port B address 0x%0h out of range", b_addr);
    end
`endif
  end

  assign a_rdata  = a_dat_q[READ_LAT-1];
  assign a_rvalid = a_vld_q[READ_LAT-1];
  assign b_rdata  = b_dat_q[READ_LAT-1];
  assign b_rvalid = b_vld_q[READ_LAT-1];

endmodule
